// File: rtl/display_nhex_scan.sv
// display_nhex_scan
//   Multiplexed seven-segment driver for DIGITS hex digits on shared
//   active-low segment lines. Inputs are captured into shadow registers on
//   'load'. Each digit slot lasts 2^DIV_BITS cycles. Within a slot, the top
//   four bits of the slot counter drive a 16-level brightness PWM. Each digit
//   can be blanked, blinked (2^BLINK_BITS period, 50% duty), or given a
//   decimal point. frame_tick pulses once at the start of every scan frame.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     When defined, zero digits to the left of the first nonzero digit are
//     dark unless their dp bit is set. The rightmost digit is always shown.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   data_in     4*DIGITS hex nibbles, MSB nibble = leftmost digit
//   dp_in       decimal point per digit (bit DIGITS-1 = leftmost)
//   blank_in    force digit dark
//   blink_in    digit dark during the blink off-phase
//   load        capture all *_in into the shadow registers
//   brightness  PWM level, 0 = dark, 15 = 15/16 on-time (not shadowed)
//   seg         segments gfedcba, active-low, registered
//   dp          decimal point, active-low, registered
//   strobe      digit enables, active-low, registered
//   frame_tick  one-cycle pulse at the start of each scan frame
module display_nhex_scan #(
    parameter int DIGITS     = 8,
    parameter int DIV_BITS   = 11,
    parameter int BLINK_BITS = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     blink_in,
    input  logic                  load,
    input  logic [3:0]            brightness,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     strobe,
    output logic                  frame_tick
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DIV_BITS-1:0]   div_cnt;
    logic [IDX_W-1:0]      idx;
    logic [BLINK_BITS-1:0] blink_cnt;

    logic [4*DIGITS-1:0]   shadow_data;
    logic [DIGITS-1:0]     shadow_dp;
    logic [DIGITS-1:0]     shadow_blank;
    logic [DIGITS-1:0]     shadow_blink;

    logic                  slot_end;
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  cur_blink;
    logic                  cur_lead_zero;
    logic [DIGITS-1:0]     strobe_sel;
    logic                  lit;
    logic [6:0]            seg_code;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h18;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h27;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign slot_end = &div_cnt;

`ifdef LEADING_ZERO_BLANK_EN
    // Leading-zero flags, walked from the leftmost nibble. A dp-marked zero
    // is shown but does not end the zero run for the digits to its right.
    logic [DIGITS-1:0] lead_zero;
    always_comb begin
        logic zero_run;
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            zero_run = zero_run & (shadow_data[4*(DIGITS-1-i) +: 4] == 4'h0);
            if (i != DIGITS - 1) begin
                lead_zero[DIGITS-1-i] = zero_run & ~shadow_dp[DIGITS-1-i];
            end
        end
    end
`endif

    // Digit selection by comparing idx against each constant position keeps
    // every part-select constant, whatever DIGITS is.
    always_comb begin
        cur_nibble    = 4'h0;
        cur_dp        = 1'b0;
        cur_blank     = 1'b0;
        cur_blink     = 1'b0;
        cur_lead_zero = 1'b0;
        strobe_sel    = '1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nibble = shadow_data[4*(DIGITS-1-k) +: 4];
                cur_dp     = shadow_dp[DIGITS-1-k];
                cur_blank  = shadow_blank[DIGITS-1-k];
                cur_blink  = shadow_blink[DIGITS-1-k];
`ifdef LEADING_ZERO_BLANK_EN
                cur_lead_zero = lead_zero[DIGITS-1-k];
`endif
                strobe_sel[DIGITS-1-k] = 1'b0;
            end
        end
    end

    always_comb begin
        lit = ~cur_blank
            & ~(cur_blink & blink_cnt[BLINK_BITS-1])
            & ~cur_lead_zero
            & (div_cnt[DIV_BITS-1 -: 4] < brightness);
        seg_code = hex_to_seg(cur_nibble);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt      <= '0;
            idx          <= '0;
            blink_cnt    <= '0;
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            shadow_blink <= '0;
            seg          <= 7'h7F;
            dp           <= 1'b1;
            strobe       <= '1;
            frame_tick   <= 1'b0;
        end else begin
            div_cnt   <= div_cnt + DIV_BITS'(1);
            blink_cnt <= blink_cnt + BLINK_BITS'(1);
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
            frame_tick <= slot_end & (idx == IDX_LAST);

            if (load) begin
                shadow_data  <= data_in;
                shadow_dp    <= dp_in;
                shadow_blank <= blank_in;
                shadow_blink <= blink_in;
            end

            // Outputs come from a single idx, so at most one strobe is low
            // even on the cycle idx advances.
            if (lit) begin
                seg    <= seg_code;
                dp     <= ~cur_dp;
                strobe <= strobe_sel;
            end else begin
                seg    <= 7'h7F;
                dp     <= 1'b1;
                strobe <= '1;
            end
        end
    end

endmodule

// File: tb/tb_display_nhex_scan.sv
module tb_display_nhex_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic [7:0]  dp_in, blank_in, blink_in;
    logic        load;
    logic [3:0]  brightness;

    logic [6:0]  seg8, seg6;
    logic        dp8, dp6;
    logic [7:0]  strobe8;
    logic [5:0]  strobe6;
    logic        ft8, ft6;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    display_nhex_scan #(.DIGITS(8), .DIV_BITS(4), .BLINK_BITS(6)) dut8 (
        .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .blink_in(blink_in), .load(load),
        .brightness(brightness), .seg(seg8), .dp(dp8), .strobe(strobe8),
        .frame_tick(ft8)
    );

    display_nhex_scan #(.DIGITS(6), .DIV_BITS(4), .BLINK_BITS(6)) dut6 (
        .clk(clk), .rst(rst), .data_in(data_in[23:0]), .dp_in(dp_in[5:0]),
        .blank_in(blank_in[5:0]), .blink_in(blink_in[5:0]), .load(load),
        .brightness(brightness), .seg(seg6), .dp(dp6), .strobe(strobe6),
        .frame_tick(ft6)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Everything is derived from the number of clock edges since reset.
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

    int unsigned cyc;
    logic [31:0] m_data;
    logic [7:0]  m_dp, m_blank, m_blink;
    bit          m_valid = 0;
    logic [6:0]  e_seg8, e_seg6;
    logic        e_dp8, e_dp6, e_ft8, e_ft6;
    logic [7:0]  e_stb8, e_stb6;

    function automatic void model(input int d, input int unsigned c, input logic [3:0] br,
                                  output logic [6:0] eseg, output logic edp,
                                  output logic [7:0] estb, output logic eft);
        int  pos, n, divv;
        bit  on;
        pos  = int'((c / 16) % d);
        n    = d - 1 - pos;
        divv = int'(c % 16);
        on   = !m_blank[n] && !(m_blink[n] && (c % 64) >= 32) && (divv < int'(br));
`ifdef LEADING_ZERO_BLANK_EN
        begin
            bit leading = 1;
            for (int j = d - 1; j >= n; j--)
                if (m_data[4*j +: 4] != 4'h0) leading = 0;
            if (leading && n != 0 && !m_dp[n]) on = 0;
        end
`endif
        eft  = ((c + 1) % (16 * d)) == 0;
        eseg = 7'h7F;
        edp  = 1'b1;
        estb = 8'hFF;
        if (on) begin
            eseg    = hex_tab[m_data[4*n +: 4]];
            edp     = ~m_dp[n];
            estb[n] = 1'b0;
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            cyc = 0; m_data = '0; m_dp = '0; m_blank = '0; m_blink = '0;
            e_seg8 = 7'h7F; e_dp8 = 1; e_stb8 = 8'hFF; e_ft8 = 0;
            e_seg6 = 7'h7F; e_dp6 = 1; e_stb6 = 8'hFF; e_ft6 = 0;
        end else begin
            model(8, cyc, brightness, e_seg8, e_dp8, e_stb8, e_ft8);
            model(6, cyc, brightness, e_seg6, e_dp6, e_stb6, e_ft6);
            cyc++;
            if (load) begin
                m_data = data_in; m_dp = dp_in; m_blank = blank_in; m_blink = blink_in;
            end
        end
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("seg8", {1'b0, seg8}, {1'b0, e_seg8});
            check("dp8", {7'b0, dp8}, {7'b0, e_dp8});
            check("strobe8", strobe8, e_stb8);
            check("frame_tick8", {7'b0, ft8}, {7'b0, e_ft8});
            check("seg6", {1'b0, seg6}, {1'b0, e_seg6});
            check("dp6", {7'b0, dp6}, {7'b0, e_dp6});
            check("strobe6", {2'b11, strobe6}, {2'b11, e_stb6[5:0]});
            check("frame_tick6", {7'b0, ft6}, {7'b0, e_ft6});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1; load = 0; data_in = '0; dp_in = '0; blank_in = '0; blink_in = '0;
        brightness = 4'd15;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lit_rst_seg", {1'b0, seg8}, 8'h7F);
        check("lit_rst_dp", {7'b0, dp8}, 8'h01);
        check("lit_rst_strobe", strobe8, 8'hFF);
        check("lit_rst_ft", {7'b0, ft8}, 8'h00);

        // Directed scan: negedge after posedge k shows state of edge count k-1.
        rst = 0; load = 1; data_in = 32'h0123ABCD;
        @(negedge clk);                       // k=1
        load = 0;
        repeat (15) @(negedge clk);           // k=16, div=15 -> dark
        check("lit_pwm_off8", strobe8, 8'hFF);
        check("lit_pwm_off6", {2'b11, strobe6}, 8'hFF);
        repeat (2) @(negedge clk);            // k=18, idx 1, div 1
        check("lit_idx1_strobe8", strobe8, 8'hBF);
        check("lit_idx1_seg8", {1'b0, seg8}, 8'h79);
        check("lit_idx1_strobe6", {2'b00, strobe6}, 8'h2F);
        check("lit_idx1_seg6", {1'b0, seg6}, 8'h30);
        repeat (78) @(negedge clk);           // k=96
        check("lit_frame6", {7'b0, ft6}, 8'h01);
        repeat (18) @(negedge clk);           // k=114, dut8 idx 7, dut6 wrapped to idx 1
        check("lit_idx7_strobe8", strobe8, 8'hFE);
        check("lit_idx7_seg8", {1'b0, seg8}, 8'h21);
        check("lit_wrap_strobe6", {2'b00, strobe6}, 8'h2F);
        repeat (14) @(negedge clk);           // k=128
        check("lit_frame8", {7'b0, ft8}, 8'h01);

`ifdef LEADING_ZERO_BLANK_EN
        load = 1; data_in = 32'h00000100; dp_in = 8'h40;
        @(negedge clk);
        load = 0;
        repeat (16) @(negedge clk);           // now in idx 1 slot
        check("lit_lz_dp_strobe", strobe8, 8'hBF);
        check("lit_lz_dp_seg", {1'b0, seg8}, 8'h40);
        check("lit_lz_dp_dp", {7'b0, dp8}, 8'h00);
        dp_in = '0;
`endif

        // Randomized phase.
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 999) == 0);
            load = ($urandom_range(0, 7) == 0);
            data_in = $urandom >> (4 * $urandom_range(0, 8));
            dp_in    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            blank_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            blink_in = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 15) == 0) brightness = 4'($urandom);
        end
        @(negedge clk);
        rst = 0; load = 0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
